// File: rtl/morse_key_receiver_pkg.sv
// Shared definitions for the Morse key receiver: code constants, symbol limit and FSM states.
package morse_key_receiver_pkg;

  localparam logic [5:0] CODE_INVALID = 6'd63;
  localparam logic [5:0] CODE_DIGIT0  = 6'd26;
  localparam logic [2:0] MAX_SYM      = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StMark,
    StSpace,
    StGap
  } rx_state_e;

endpackage

// File: rtl/morse_key_receiver_if.sv
// Key input and decoded symbol/character outputs of the Morse key receiver.
interface morse_key_receiver_if;
  logic       en;
  logic       clear;
  logic       key_in;
  logic       sym_valid;
  logic       sym_is_dash;
  logic [4:0] sym_buf;
  logic [2:0] sym_cnt;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_err;
  logic       word_gap;
  logic       busy;

  modport master (
    output en, clear, key_in,
    input  sym_valid, sym_is_dash, sym_buf, sym_cnt, char_valid, char_code, char_err,
           word_gap, busy
  );

  modport slave (
    input  en, clear, key_in,
    output sym_valid, sym_is_dash, sym_buf, sym_cnt, char_valid, char_code, char_err,
           word_gap, busy
  );
endinterface

// File: rtl/morse_key_receiver_lut.sv
// Symbol pattern to character code table; bit i of sym_buf is symbol i, 1 = dash.
module morse_key_receiver_lut
  import morse_key_receiver_pkg::*;
(
  input  logic [2:0] sym_cnt,
  input  logic [4:0] sym_buf,
  output logic       hit,
  output logic [5:0] code
);
  always_comb begin
    hit  = 1'b1;
    code = CODE_INVALID;
    case ({sym_cnt, sym_buf})
      8'b010_00010: code = 6'd0;   // A .-
      8'b100_00001: code = 6'd1;   // B -...
      8'b100_00101: code = 6'd2;   // C -.-.
      8'b011_00001: code = 6'd3;   // D -..
      8'b001_00000: code = 6'd4;   // E .
      8'b100_00100: code = 6'd5;   // F ..-.
      8'b011_00011: code = 6'd6;   // G --.
      8'b100_00000: code = 6'd7;   // H ....
      8'b010_00000: code = 6'd8;   // I ..
      8'b100_01110: code = 6'd9;   // J .---
      8'b011_00101: code = 6'd10;  // K -.-
      8'b100_00010: code = 6'd11;  // L .-..
      8'b010_00011: code = 6'd12;  // M --
      8'b010_00001: code = 6'd13;  // N -.
      8'b011_00111: code = 6'd14;  // O ---
      8'b100_00110: code = 6'd15;  // P .--.
      8'b100_01011: code = 6'd16;  // Q --.-
      8'b011_00010: code = 6'd17;  // R .-.
      8'b011_00000: code = 6'd18;  // S ...
      8'b001_00001: code = 6'd19;  // T -
      8'b011_00100: code = 6'd20;  // U ..-
      8'b100_01000: code = 6'd21;  // V ...-
      8'b011_00110: code = 6'd22;  // W .--
      8'b100_01001: code = 6'd23;  // X -..-
      8'b100_01101: code = 6'd24;  // Y -.--
      8'b100_00011: code = 6'd25;  // Z --..
      8'b101_11111: code = CODE_DIGIT0;
      8'b101_11110: code = CODE_DIGIT0 + 6'd1;
      8'b101_11100: code = CODE_DIGIT0 + 6'd2;
      8'b101_11000: code = CODE_DIGIT0 + 6'd3;
      8'b101_10000: code = CODE_DIGIT0 + 6'd4;
      8'b101_00000: code = CODE_DIGIT0 + 6'd5;
      8'b101_00001: code = CODE_DIGIT0 + 6'd6;
      8'b101_00011: code = CODE_DIGIT0 + 6'd7;
      8'b101_00111: code = CODE_DIGIT0 + 6'd8;
      8'b101_01111: code = CODE_DIGIT0 + 6'd9;
      default: begin
        hit  = 1'b0;
        code = CODE_INVALID;
      end
    endcase
  end
endmodule

// File: rtl/morse_key_receiver.sv
// Morse straight-key receiver: times marks and spaces, builds dot/dash symbols and
// emits a character code when the letter gap expires.
module morse_key_receiver
  import morse_key_receiver_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES      = 10_000_000,
  parameter int unsigned DASH_UNITS       = 2,
  parameter int unsigned LETTER_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS   = 7
) (
  input logic                 clk,
  input logic                 rst,
  morse_key_receiver_if.slave bus
);
  localparam int unsigned     PreW    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PreW-1:0] PreMax  = PreW'(UNIT_CYCLES - 1);
  localparam logic [3:0]      DashU   = 4'(DASH_UNITS);
  localparam logic [3:0]      LetterU = 4'(LETTER_GAP_UNITS);
  localparam logic [3:0]      WordU   = 4'(WORD_GAP_UNITS);

  rx_state_e       state_q, state_d;
  logic            key_q, rise, fall, hold_idle;
  logic [PreW-1:0] presc_q, presc_d;
  logic [3:0]      unit_q, unit_d;
  logic [4:0]      buf_q, buf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            sym_valid_q, sym_valid_d;
  logic            sym_dash_q, sym_dash_d;
  logic            char_valid_q, char_valid_d;
  logic            char_err_q, char_err_d;
  logic [5:0]      code_q, code_d;
  logic            word_gap_q, word_gap_d;
  logic            letter_exp, word_exp, is_dash, lut_hit, err;
  logic [5:0]      lut_code;

  assign hold_idle  = ~bus.en | bus.clear;
  assign rise       = bus.key_in & ~key_q;
  assign fall       = ~bus.key_in & key_q;
  assign is_dash    = (unit_q >= DashU);
  assign letter_exp = (state_q == StSpace) && (unit_q >= LetterU);
  assign word_exp   = (state_q == StGap) && (unit_q >= WordU);
  assign err        = ovf_q | ~lut_hit;

  morse_key_receiver_lut u_lut (
    .sym_cnt (cnt_q),
    .sym_buf (buf_q),
    .hit     (lut_hit),
    .code    (lut_code)
  );

  // Unit timer restarts on every key edge so marks and spaces are measured from their start.
  always_comb begin
    presc_d = presc_q;
    unit_d  = unit_q;
    if (hold_idle || rise || fall) begin
      presc_d = '0;
      unit_d  = '0;
    end else if (presc_q == PreMax) begin
      presc_d = '0;
      if (unit_q != 4'd15) unit_d = unit_q + 4'd1;
    end else begin
      presc_d = presc_q + PreW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // A rise always wins so a press landing on the letter-gap cycle still opens a new mark.
  always_comb begin
    state_d = state_q;
    if (hold_idle) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (rise) state_d = StMark;
        StMark:  if (fall) state_d = StSpace;
        StSpace: begin
          if (rise)            state_d = StMark;
          else if (letter_exp) state_d = StGap;
        end
        StGap: begin
          if (rise)          state_d = StMark;
          else if (word_exp) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    sym_valid_d  = 1'b0;
    sym_dash_d   = sym_dash_q;
    char_valid_d = 1'b0;
    char_err_d   = char_err_q;
    code_d       = code_q;
    word_gap_d   = 1'b0;
    if (hold_idle) begin
      buf_d      = '0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      sym_dash_d = 1'b0;
      char_err_d = 1'b0;
      code_d     = CODE_INVALID;
    end else begin
      if ((state_q == StMark) && fall) begin
        if (cnt_q == MAX_SYM) begin
          ovf_d = 1'b1;
        end else begin
          buf_d[cnt_q] = is_dash;
          cnt_d        = cnt_q + 3'd1;
          sym_valid_d  = 1'b1;
          sym_dash_d   = is_dash;
        end
      end
      if (letter_exp) begin
        char_valid_d = 1'b1;
        char_err_d   = err;
        code_d       = err ? CODE_INVALID : lut_code;
        buf_d        = '0;
        cnt_d        = '0;
        ovf_d        = 1'b0;
      end
      if (word_exp && !rise) word_gap_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q        <= 1'b0;
      presc_q      <= '0;
      unit_q       <= '0;
      buf_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      sym_valid_q  <= 1'b0;
      sym_dash_q   <= 1'b0;
      char_valid_q <= 1'b0;
      char_err_q   <= 1'b0;
      code_q       <= CODE_INVALID;
      word_gap_q   <= 1'b0;
    end else begin
      key_q        <= bus.key_in;
      presc_q      <= presc_d;
      unit_q       <= unit_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      sym_valid_q  <= sym_valid_d;
      sym_dash_q   <= sym_dash_d;
      char_valid_q <= char_valid_d;
      char_err_q   <= char_err_d;
      code_q       <= code_d;
      word_gap_q   <= word_gap_d;
    end
  end

  assign bus.sym_valid   = sym_valid_q;
  assign bus.sym_is_dash = sym_dash_q;
  assign bus.sym_buf     = buf_q;
  assign bus.sym_cnt     = cnt_q;
  assign bus.char_valid  = char_valid_q;
  assign bus.char_code   = code_q;
  assign bus.char_err    = char_err_q;
  assign bus.word_gap    = word_gap_q;
  assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_morse_key_receiver.sv
// Directed bench for morse_key_receiver with UNIT_CYCLES=10 and default gap/dash settings.
module tb_morse_key_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morse_key_receiver_if bus ();

  morse_key_receiver #(
    .UNIT_CYCLES      (10),
    .DASH_UNITS       (2),
    .LETTER_GAP_UNITS (3),
    .WORD_GAP_UNITS   (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_sym = 0, n_char = 0, n_wg = 0;
  int          s_sym, s_char, s_wg;
  logic [15:0] sym_log   = '0;
  logic [5:0]  last_code = '0;
  logic [5:0]  prev_code = '0;
  logic        last_err  = 1'b0;

  // Pulse monitor samples just after the active edge.
  always @(posedge clk) begin
    #1;
    if (bus.sym_valid) begin
      n_sym++;
      sym_log = {sym_log[14:0], bus.sym_is_dash};
    end
    if (bus.char_valid) begin
      n_char++;
      prev_code = last_code;
      last_code = bus.char_code;
      last_err  = bus.char_err;
    end
    if (bus.word_gap) n_wg++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int on_cyc, input int off_cyc);
    bus.key_in = 1'b1;
    cycles(on_cyc);
    bus.key_in = 1'b0;
    cycles(off_cyc);
  endtask

  task automatic snap();
    s_sym  = n_sym;
    s_char = n_char;
    s_wg   = n_wg;
  endtask

  initial begin
    bus.en     = 1'b1;
    bus.clear  = 1'b0;
    bus.key_in = 1'b0;
    cycles(3);
    check("rst_busy", bus.busy, 0);
    check("rst_cnt", bus.sym_cnt, 0);
    check("rst_buf", bus.sym_buf, 0);
    check("rst_code", bus.char_code, 63);
    check("rst_err", bus.char_err, 0);
    check("rst_pulses", {bus.sym_valid, bus.char_valid, bus.word_gap}, 0);
    rst = 1'b0;
    cycles(2);

    // 'A': dot then dash
    snap();
    press(10, 10);
    press(25, 40);
    check("a_syms", n_sym - s_sym, 2);
    check("a_pattern", sym_log[1:0], 2'b01);
    check("a_chars", n_char - s_char, 1);
    check("a_code", last_code, 0);
    check("a_err", last_err, 0);
    check("a_busy_gap", bus.busy, 1);
    check("a_cnt_clr", bus.sym_cnt, 0);

    // Silence continues past the word gap
    cycles(40);
    check("wg_pulses", n_wg - s_wg, 1);
    check("wg_busy", bus.busy, 0);
    check("wg_code_held", bus.char_code, 0);

    // '0': five dashes
    snap();
    repeat (4) press(30, 10);
    press(30, 40);
    check("d0_syms", n_sym - s_sym, 5);
    check("d0_pattern", sym_log[4:0], 5'b11111);
    check("d0_chars", n_char - s_char, 1);
    check("d0_code", last_code, 26);
    check("d0_err", last_err, 0);

    // Six dots overflow the buffer
    snap();
    repeat (5) press(10, 10);
    press(10, 40);
    check("ovf_syms", n_sym - s_sym, 5);
    check("ovf_chars", n_char - s_char, 1);
    check("ovf_code", last_code, 63);
    check("ovf_err", last_err, 1);

    // 'E' whose letter gap expires on the same cycle as the next rise, then 'T'
    snap();
    press(10, 31);
    press(25, 40);
    check("edge_chars", n_char - s_char, 2);
    check("edge_first", prev_code, 4);
    check("edge_second", last_code, 19);
    check("edge_err", last_err, 0);
    check("edge_syms", n_sym - s_sym, 2);
    check("edge_pattern", sym_log[1:0], 2'b01);

    // Disabled receiver ignores the key
    bus.en = 1'b0;
    snap();
    press(10, 10);
    press(25, 80);
    check("en0_syms", n_sym - s_sym, 0);
    check("en0_chars", n_char - s_char, 0);
    check("en0_wg", n_wg - s_wg, 0);
    check("en0_busy", bus.busy, 0);
    check("en0_code", bus.char_code, 63);
    bus.en = 1'b1;
    cycles(2);

    // Clear drops a partial character
    snap();
    press(10, 10);
    press(10, 5);
    bus.clear = 1'b1;
    cycles(1);
    bus.clear = 1'b0;
    check("clr_busy", bus.busy, 0);
    check("clr_cnt", bus.sym_cnt, 0);
    cycles(40);
    check("clr_syms", n_sym - s_sym, 2);
    check("clr_chars", n_char - s_char, 0);

    // Reset in the middle of a mark with three symbols held
    snap();
    repeat (3) press(10, 10);
    bus.key_in = 1'b1;
    cycles(5);
    check("mid_cnt", bus.sym_cnt, 3);
    check("mid_busy", bus.busy, 1);
    rst = 1'b1;
    cycles(1);
    check("mrst_busy", bus.busy, 0);
    check("mrst_cnt", bus.sym_cnt, 0);
    check("mrst_buf", bus.sym_buf, 0);
    check("mrst_pulses", {bus.sym_valid, bus.char_valid, bus.word_gap}, 0);
    rst = 1'b0;
    bus.key_in = 1'b0;
    cycles(10);
    press(25, 40);
    check("post_rst_syms", n_sym - s_sym, 4);
    check("post_rst_chars", n_char - s_char, 1);
    check("post_rst_code", last_code, 19);

    // Very long mark saturates the unit counter and is still a dash
    cycles(50);
    snap();
    press(170, 40);
    check("sat_syms", n_sym - s_sym, 1);
    check("sat_dash", sym_log[0], 1);
    check("sat_code", last_code, 19);
    check("sat_chars", n_char - s_char, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
